// File: rtl/register_file.sv
// Two-read, one-write register file with a hardwired-zero entry 0 and a
// sequential clear sweep that zeroes every entry after reset or on request.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0] read_value_1,
  output logic [DATA_WIDTH-1:0] read_value_2,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_value,
  input  logic                  write_enable,
  input  logic                  clear,
  output logic                  ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] index;
  logic [ADDR_WIDTH-1:0] index_next;
  logic [DATA_WIDTH-1:0] entries [DEPTH];
  logic                  sweep_start;
  logic                  write_commit;

  // Reset is just a clear request that wins over everything else.
  always_comb begin
    sweep_start  = reset | clear;
    write_commit = (state == IDLE) && !sweep_start && write_enable &&
                   (write_address != '0);
  end

  always_comb begin
    state_next = state;
    index_next = index;
    if (sweep_start) begin
      state_next = CLEAR;
      index_next = '0;
    end else if (state == CLEAR) begin
      index_next = index + 1'b1;
      if (index == '1) begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    state <= state_next;
    index <= index_next;
  end

  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      entries[index] <= '0;
    end else if (write_commit) begin
      entries[write_address] <= write_value;
    end
  end

  // Bypass only forwards a write that will actually commit on this edge.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] address);
    logic [DATA_WIDTH-1:0] value;
    value = '0;
    if (state == IDLE && address != '0) begin
      if (write_commit && write_address == address) begin
        value = write_value;
      end else begin
        value = entries[address];
      end
    end
    return value;
  endfunction

  always_comb begin
    read_value_1 = read_port(read_address_1);
    read_value_2 = read_port(read_address_2);
  end

  assign ready = (state == IDLE);

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, the register width in bits.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 6, the address width; there are 2**ADDR_WIDTH (64) entries.
REQ-003 The block SHALL have port clock, input, 1, the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the reset; synchronous, active-high.
REQ-005 The block SHALL have port read_address_1, input, ADDR_WIDTH, the read port 1 address.
REQ-006 The block SHALL have port read_address_2, input, ADDR_WIDTH, the read port 2 address.
REQ-007 The block SHALL have port read_value_1, output, DATA_WIDTH, the read port 1 data.
REQ-008 The block SHALL have port read_value_2, output, DATA_WIDTH, the read port 2 data.
REQ-009 The block SHALL have port write_address, input, ADDR_WIDTH, the write port address.
REQ-010 The block SHALL have port write_value, input, DATA_WIDTH, the write port data.
REQ-011 The block SHALL have port write_enable, input, 1, which commits the write on the edge.
REQ-012 The block SHALL have port clear, input, 1, a synchronous request to zero all entries (the processor's register_file_reset).
REQ-013 The block SHALL have port ready, output, 1: high when in IDLE; low while a clear sweep is in progress.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE, CLEAR; with an ADDR_WIDTH-bit sweep index.
REQ-015 Reads SHALL be combinational (zero latency) from address to value on both ports, independently; both ports may use the same address.
REQ-016 Entry 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-017 In IDLE, write_enable=1 with write_address!=0 SHALL store write_value into that entry at the edge.
REQ-018 In IDLE, a read address equal to a nonzero write_address with write_enable=1 SHALL return write_value in the same cycle (write-first bypass), per port.
REQ-019 In CLEAR, both read ports SHALL return 0 regardless of address, and all writes SHALL be discarded; no bypass.
REQ-020 In CLEAR, each edge SHALL write 0 to entry[index] and increment index; the edge that clears index 2**ADDR_WIDTH-1 SHALL move the FSM to IDLE (index wraps to 0).
REQ-021 clear=1 sampled in IDLE SHALL enter CLEAR with index 0 on that edge; any write presented on that edge SHALL be discarded.
REQ-022 clear=1 sampled in CLEAR SHALL restart the sweep at index 0 (no early exit).
REQ-023 A full sweep SHALL hold ready=0 for exactly 64 cycles after the initiating edge; ready SHALL be 1 after the 64th sweep edge.
REQ-024 ready SHALL be driven from the FSM state register only, never combinationally from inputs.

Reset
REQ-025 reset=1 SHALL behave as clear=1 with priority over clear and write_enable: state CLEAR, index 0, ready 0.
REQ-026 reset asserted mid-sweep SHALL restart the sweep at index 0.
REQ-027 Array contents SHALL be undefined only until the first completed sweep; outputs SHALL never expose them, since reads return 0 during CLEAR.
REQ-028 Write data SHALL be stored unaltered at full DATA_WIDTH; there are no arithmetic or width conversions.

Verification
REQ-029 Reset 1 cycle -> ready=0 for 64 cycles, then 1; read_value_1/2 = 0 for addresses 0, 1, 63.
REQ-030 Write addr 5 = 0xDEADBEEF with read_address_1 = 5 in the same cycle -> read_value_1 = 0xDEADBEEF that cycle (bypass) and on all later cycles.
REQ-031 Write addr 0 = 0x00001234, then read addr 0 on both ports -> 0x00000000.
REQ-032 Write addr 63 = 0xA5A5A5A5 and addr 1 = 0x5A5A5A5A; read port 1 = 63, port 2 = 1 -> both values correct simultaneously.
REQ-033 After writes, pulse clear; write addr 7 = 0xFFFFFFFF during the sweep -> ready low 64 cycles; afterwards addr 7 and addr 63 read 0.
REQ-034 Re-pulse clear (or reset) 20 cycles into a sweep -> ready returns high exactly 64 cycles after the re-pulse edge.
